spi_frame_ctrl: RTL and testbench

- Frame sequencer for spiifc. Snoops spiifc's receive-memory write strobe and SPI_SS to find frame boundaries.
- Captures each frame's command byte and length.
- Manages ping-pong bank selection for the rc and tx memories (bank bit = address MSB above spiifc's 12-bit addresses).
- Handshakes each completed frame to the host side. Sits between spiifc, the dual-bank BRAMs and host logic.

---
 rtl/spi_frame_ctrl_if.sv | 58 +++++
 rtl/spi_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl_if
//   Bundles the signals that spi_frame_ctrl exchanges with spiifc, with the
//   dual-bank BRAM address MSBs and with host logic.
//
//   slave  modport : used by spi_frame_ctrl (snoops spiifc, drives bank
//                    selects, frame publish handshake and status flags).
//   master modport : used by whatever drives spiifc snoop and host signals.
//
//   spiifc side : SPI_SS, rcMemWE, rcMemData               (into the sequencer)
//   bank select : rcBank, txBank                            (out of the sequencer)
//   host side   : hostRcAck, hostRcAckBank, hostTxReady     (into the sequencer)
//                 frameDone, frameBank, frameCmd, frameLen,
//                 rcFull, overrun, lenErr, busy             (out of the sequencer)
//   Optional    : timeout, present only when SPI_FRAME_CTRL_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
interface spi_frame_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic              SPI_SS;
   logic              rcMemWE;
   logic [7:0]        rcMemData;
   logic              hostRcAck;
   logic              hostRcAckBank;
   logic              hostTxReady;

   logic              rcBank;
   logic              txBank;
   logic              frameDone;
   logic              frameBank;
   logic [7:0]        frameCmd;
   logic [ADDR_W:0]   frameLen;
   logic [1:0]        rcFull;
   logic              overrun;
   logic              lenErr;
   logic              busy;
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
   logic              timeout;
`endif

   modport slave (
      input  SPI_SS, rcMemWE, rcMemData, hostRcAck, hostRcAckBank, hostTxReady,
      output rcBank, txBank, frameDone, frameBank, frameCmd, frameLen,
             rcFull, overrun, lenErr, busy
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
      , timeout
`endif
   );

   modport master (
      output SPI_SS, rcMemWE, rcMemData, hostRcAck, hostRcAckBank, hostTxReady,
      input  rcBank, txBank, frameDone, frameBank, frameCmd, frameLen,
             rcFull, overrun, lenErr, busy
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
      , timeout
`endif
   );
endinterface

// File: rtl/spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl
//   Frame sequencer for spiifc. Finds frame boundaries from SPI_SS, counts the
//   received bytes, keeps the first byte as the command, ping-pongs the rc and
//   tx BRAM banks and publishes each non-empty frame to the host with a
//   one-cycle frameDone pulse.
//
//   Ports
//     SysClk : system clock, rising edge
//     Reset  : synchronous, active-low (0 = reset)
//     bus    : spi_frame_ctrl_if.slave (spiifc snoop, bank selects, host
//              handshake and status flags)
//
//   Optional feature (macro SPI_FRAME_CTRL_TIMEOUT_EN):
//     a 16-bit idle-byte watchdog aborts a frame after TIMEOUT_CYC cycles in
//     ACTIVE without a byte, pulses bus.timeout and waits for SS to go high.
// -----------------------------------------------------------------------------
module spi_frame_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int MAX_LEN = 4096
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 65535
`endif
) (
   input logic             SysClk,
   input logic             Reset,
   spi_frame_ctrl_if.slave bus
);
   typedef enum logic [1:0] {WAIT_HI, IDLE, ACTIVE, CLOSE} state_t;

   localparam int              CW      = ADDR_W + 1;
   localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_LEN);

   state_t          state;
   logic            ss1, ss2, ss3;
   logic [1:0]      primed;      // fills with 1s after reset once ss2 is pin-derived
   logic [CW-1:0]   count;
   logic [7:0]      cmd;
   logic            tx_pend;

   logic            rc_bank, tx_bank, frame_done, frame_bank;
   logic [7:0]      frame_cmd;
   logic [CW-1:0]   frame_len;
   logic [1:0]      rc_full;
   logic            overrun, len_err, busy;

   logic            ss_start, ss_end, tx_pend_now, publish;
   logic [1:0]      full_acked, full_next;

`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0]     wd;
   logic            timeout_q;
`endif

   assign ss_start    = ~ss2 & ss3;
   assign ss_end      =  ss2 & ~ss3;
   assign tx_pend_now = tx_pend | bus.hostTxReady;
   assign publish     = (state == CLOSE) && (count != '0);

   // The host ack is applied before the publish: the bank-swap decision sees
   // the just-freed bank, and a publish into the acked bank re-sets its flag.
   // NOTE: combinational logic uses blocking '=' with a default first so no latch is inferred.
   always_comb begin
      full_acked = rc_full;
      if (bus.hostRcAck) full_acked[bus.hostRcAckBank] = 1'b0;
      full_next = full_acked;
      if (publish) full_next[rc_bank] = 1'b1;
   end

   // NOTE: all state is updated with non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge SysClk) begin
      if (!Reset) begin
         state      <= WAIT_HI;
         ss1        <= 1'b1;   // idle level, so reset itself produces no edge
         ss2        <= 1'b1;
         ss3        <= 1'b1;
         primed     <= '0;
         count      <= '0;
         cmd        <= '0;
         tx_pend    <= 1'b0;
         rc_bank    <= 1'b0;
         tx_bank    <= 1'b0;
         frame_done <= 1'b0;
         frame_bank <= 1'b0;
         frame_cmd  <= '0;
         frame_len  <= '0;
         rc_full    <= '0;
         overrun    <= 1'b0;
         len_err    <= 1'b0;
         busy       <= 1'b0;
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
         wd         <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         ss1        <= bus.SPI_SS;
         ss2        <= ss1;
         ss3        <= ss2;
         primed     <= {primed[0], 1'b1};
         frame_done <= 1'b0;
         rc_full    <= full_next;
         tx_pend    <= tx_pend_now;
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
         if (bus.hostRcAck && rc_full == 2'b11) overrun <= 1'b0;

         case (state)
            // ss2 still holds its reset value for two cycles; waiting for
            // primed keeps a frame that straddled reset from looking new.
            WAIT_HI: if (primed[1] && ss2) state <= IDLE;

            IDLE: begin
               if (ss_start) begin
                  state <= ACTIVE;
                  busy  <= 1'b1;
                  count <= '0;
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
                  wd    <= '0;
`endif
                  // tx banks only swap between frames.
                  if (tx_pend_now) begin
                     tx_bank <= ~tx_bank;
                     tx_pend <= 1'b0;
                  end
               end
            end

            ACTIVE: begin
               if (bus.rcMemWE) begin
                  if (count == '0) cmd <= bus.rcMemData;
                  if (count == MAX_CNT) len_err <= 1'b1;
                  else                  count   <= count + 1'b1;
               end
               if (ss_end) begin
                  state <= CLOSE;
                  busy  <= 1'b0;
               end
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
               else if (!bus.rcMemWE && wd == WD_LAST) begin
                  state     <= WAIT_HI;
                  busy      <= 1'b0;
                  timeout_q <= 1'b1;
               end
               wd <= bus.rcMemWE ? '0 : wd + 16'd1;
`endif
            end

            CLOSE: begin
               state <= IDLE;
               if (publish) begin
                  frame_done <= 1'b1;
                  frame_bank <= rc_bank;
                  frame_len  <= count;
                  frame_cmd  <= cmd;
                  // With no free bank spiifc keeps writing the same bank.
                  if (!full_acked[~rc_bank]) rc_bank <= ~rc_bank;
                  else                       overrun <= 1'b1;
               end
            end

            default: state <= WAIT_HI;
         endcase
      end
   end

   assign bus.rcBank    = rc_bank;
   assign bus.txBank    = tx_bank;
   assign bus.frameDone = frame_done;
   assign bus.frameBank = frame_bank;
   assign bus.frameCmd  = frame_cmd;
   assign bus.frameLen  = frame_len;
   assign bus.rcFull    = rc_full;
   assign bus.overrun   = overrun;
   assign bus.lenErr    = len_err;
   assign bus.busy      = busy;
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
   assign bus.timeout   = timeout_q;
`endif
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_ctrl
//   Directed-stimulus bench for spi_frame_ctrl. A frame-level reference model
//   (bank flags, byte count, publish record) is advanced once per clock by the
//   stimulus tasks; a compare process checks every DUT output against it on
//   each falling edge, and literal expectations after each scenario pin the
//   model. With SPI_FRAME_CTRL_TIMEOUT_EN defined the watchdog is also run
//   with TIMEOUT_CYC = 100.
// -----------------------------------------------------------------------------
module tb_spi_frame_ctrl;
   localparam int ADDR_W  = 12;
   localparam int MAX_LEN = 4096;

   logic SysClk = 1'b0;
   logic Reset  = 1'b0;
   always #5 SysClk = ~SysClk;

   spi_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   spi_frame_ctrl #(
      .ADDR_W (ADDR_W),
      .MAX_LEN(MAX_LEN)
`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(100)
`endif
   ) dut (
      .SysClk(SysClk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic       m_rc_bank, m_tx_bank, m_done, m_fbank, m_busy;
   logic       m_overrun, m_len_err, m_tx_pend, m_wait_hi, m_close_pend;
   logic [1:0] m_rc_full;
   logic [7:0] m_fcmd, m_cmd;
   int         m_count, m_flen;
   bit         ev_start = 1'b0, ev_end = 1'b0, ev_close = 1'b0;

   // One clock edge: inputs are captured before the edge, the model is
   // advanced just after it, inputs may then be changed by the caller.
   task automatic tick();
      logic       rst_s, ack, ackb, txr, we, ss, busy_pre;
      logic [1:0] full_pre;
      logic [7:0] d;
      rst_s = Reset;          ack = bus.hostRcAck; ackb = bus.hostRcAckBank;
      txr   = bus.hostTxReady; we = bus.rcMemWE;   ss   = bus.SPI_SS;
      d     = bus.rcMemData;
      @(posedge SysClk);
      #1;
      m_done = 1'b0;
      if (!rst_s) begin
         m_rc_bank = 0; m_tx_bank = 0; m_fbank = 0; m_busy = 0; m_overrun = 0;
         m_len_err = 0; m_tx_pend = 0; m_close_pend = 0; m_rc_full = 2'b00;
         m_fcmd = 8'h00; m_cmd = 8'h00; m_count = 0; m_flen = 0; m_wait_hi = 1;
         return;
      end
      busy_pre = m_busy;
      full_pre = m_rc_full;
      if (ack) begin
         if (full_pre == 2'b11) m_overrun = 1'b0;
         m_rc_full[ackb] = 1'b0;
      end
      if (txr) m_tx_pend = 1'b1;
      if (ev_start && !m_busy && !m_wait_hi) begin
         m_busy  = 1'b1;
         m_count = 0;
         if (m_tx_pend) begin
            m_tx_bank = ~m_tx_bank;
            m_tx_pend = 1'b0;
         end
      end
      if (we && busy_pre) begin
         if (m_count == MAX_LEN) m_len_err = 1'b1;
         else begin
            if (m_count == 0) m_cmd = d;
            m_count++;
         end
      end
      if (ev_end && busy_pre) begin
         m_busy       = 1'b0;
         m_close_pend = 1'b1;
      end else if (ev_close && m_close_pend) begin
         m_close_pend = 1'b0;
         if (m_count != 0) begin
            m_done  = 1'b1;
            m_fbank = m_rc_bank;
            m_flen  = m_count;
            m_fcmd  = m_cmd;
            m_rc_full[m_rc_bank] = 1'b1;
            if (!m_rc_full[~m_rc_bank]) m_rc_bank = ~m_rc_bank;
            else                        m_overrun = 1'b1;
         end
      end
      if (ss) m_wait_hi = 1'b0;
   endtask

   // ---------------- compare process ----------------
   always @(negedge SysClk) begin
      if (bus.frameDone === 1'b1) done_cnt++;
      if (check_en) begin
         check("cmp_rcBank",    32'(bus.rcBank),    32'(m_rc_bank));
         check("cmp_txBank",    32'(bus.txBank),    32'(m_tx_bank));
         check("cmp_frameDone", 32'(bus.frameDone), 32'(m_done));
         check("cmp_frameBank", 32'(bus.frameBank), 32'(m_fbank));
         check("cmp_frameCmd",  32'(bus.frameCmd),  32'(m_fcmd));
         check("cmp_frameLen",  32'(bus.frameLen),  m_flen);
         check("cmp_rcFull",    32'(bus.rcFull),    32'(m_rc_full));
         check("cmp_overrun",   32'(bus.overrun),   32'(m_overrun));
         check("cmp_lenErr",    32'(bus.lenErr),    32'(m_len_err));
         check("cmp_busy",      32'(bus.busy),      32'(m_busy));
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [7:0] byte_at(input int i, input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
      case (i)
         0:       return b0;
         1:       return b1;
         2:       return b2;
         default: return 8'(i * 7 + 3);
      endcase
   endfunction

   task automatic do_reset();
      Reset = 1'b0;
      repeat (2) tick();
      Reset = 1'b1;
      repeat (5) tick();
   endtask

   // One SS-low window carrying n bytes. txr_at: byte index that also pulses
   // hostTxReady (-1 none); txr_start: pulse hostTxReady on the Start edge;
   // ack_close: bank acked in the CLOSE cycle (-1 none).
   task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input int txr_at, input bit txr_start, input int ack_close);
      bus.SPI_SS = 1'b0;
      tick(); tick();
      if (txr_start) bus.hostTxReady = 1'b1;
      ev_start = 1'b1; tick(); ev_start = 1'b0;
      bus.hostTxReady = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.rcMemWE   = 1'b1;
         bus.rcMemData = byte_at(i, b0, b1, b2);
         if (i == txr_at) bus.hostTxReady = 1'b1;
         tick();
         bus.hostTxReady = 1'b0;
      end
      bus.rcMemWE = 1'b0;
      bus.SPI_SS  = 1'b1;
      tick(); tick();
      ev_end = 1'b1; tick(); ev_end = 1'b0;
      ev_close = 1'b1;
      if (ack_close >= 0) begin
         bus.hostRcAck     = 1'b1;
         bus.hostRcAckBank = ack_close[0];
      end
      tick();
      ev_close = 1'b0;
      bus.hostRcAck = 1'b0;
      repeat (3) tick();
   endtask

   task automatic ack_bank(input logic b);
      bus.hostRcAck     = 1'b1;
      bus.hostRcAckBank = b;
      tick();
      bus.hostRcAck = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 1ms");
      $fatal(1, "bench timeout");
   end

   initial begin
      int d0;
      bus.SPI_SS = 1'b1; bus.rcMemWE = 1'b0; bus.rcMemData = 8'h00;
      bus.hostRcAck = 1'b0; bus.hostRcAckBank = 1'b0; bus.hostTxReady = 1'b0;

      // ---- reset state ----
      Reset = 1'b0;
      tick();
      check_en = 1'b1;
      do_reset();
      check("rst_rcBank", 32'(bus.rcBank), 0);
      check("rst_rcFull", 32'(bus.rcFull), 0);
      check("rst_frameLen", 32'(bus.frameLen), 0);

      // ---- basic 3-byte frame; a stray byte strobe in IDLE comes first ----
      bus.rcMemWE = 1'b1; bus.rcMemData = 8'hEE; tick(); bus.rcMemWE = 1'b0; tick();
      d0 = done_cnt;
      frame(3, 8'hA5, 8'h01, 8'h02, -1, 1'b0, -1);
      check("t1_done_once", done_cnt - d0, 1);
      check("t1_frameCmd", 32'(bus.frameCmd), 32'h A5);
      check("t1_frameLen", 32'(bus.frameLen), 3);
      check("t1_frameBank", 32'(bus.frameBank), 0);
      check("t1_rcFull", 32'(bus.rcFull), 32'b01);
      check("t1_rcBank", 32'(bus.rcBank), 1);
      check("t1_busy", 32'(bus.busy), 0);

      // ---- three frames without ack -> overrun ----
      do_reset();
      frame(2, 8'h11, 8'h12, 8'h00, -1, 1'b0, -1);
      frame(2, 8'h21, 8'h22, 8'h00, -1, 1'b0, -1);
      frame(2, 8'h31, 8'h32, 8'h00, -1, 1'b0, -1);
      check("t2_frameBank", 32'(bus.frameBank), 1);
      check("t2_rcFull", 32'(bus.rcFull), 32'b11);
      check("t2_overrun", 32'(bus.overrun), 1);
      check("t2_rcBank", 32'(bus.rcBank), 1);
      check("t2_frameCmd", 32'(bus.frameCmd), 32'h31);
      ack_bank(1'b0);
      check("t2_ack_rcFull", 32'(bus.rcFull), 32'b10);
      check("t2_ack_overrun", 32'(bus.overrun), 0);

      // ---- tx bank handshake ----
      frame(2, 8'h40, 8'h41, 8'h00, 1, 1'b0, -1);
      check("t3_txBank_held", 32'(bus.txBank), 0);
      frame(1, 8'h50, 8'h00, 8'h00, -1, 1'b0, -1);
      check("t3_txBank_swapped", 32'(bus.txBank), 1);
      frame(1, 8'h60, 8'h00, 8'h00, -1, 1'b1, -1);
      check("t3_txBank_coincident", 32'(bus.txBank), 0);
      frame(1, 8'h70, 8'h00, 8'h00, -1, 1'b0, -1);
      check("t3_txPend_cleared", 32'(bus.txBank), 0);
      check("t3_rcFull", 32'(bus.rcFull), 32'b11);
      check("t3_rcBank", 32'(bus.rcBank), 0);

      // ---- empty frame ----
      d0 = done_cnt;
      frame(0, 8'h00, 8'h00, 8'h00, -1, 1'b0, -1);
      check("t4_no_done", done_cnt - d0, 0);
      check("t4_rcBank", 32'(bus.rcBank), 0);
      check("t4_rcFull", 32'(bus.rcFull), 32'b11);

      // ---- ack coinciding with CLOSE ----
      frame(1, 8'h80, 8'h00, 8'h00, -1, 1'b0, 1);
      check("t5_rcFull", 32'(bus.rcFull), 32'b01);
      check("t5_rcBank", 32'(bus.rcBank), 1);
      check("t5_overrun", 32'(bus.overrun), 0);
      check("t5_frameBank", 32'(bus.frameBank), 0);
      frame(1, 8'h90, 8'h00, 8'h00, -1, 1'b0, 1);
      check("t5_same_rcFull", 32'(bus.rcFull), 32'b11);
      check("t5_same_overrun", 32'(bus.overrun), 1);
      check("t5_same_rcBank", 32'(bus.rcBank), 1);
      check("t5_same_frameBank", 32'(bus.frameBank), 1);

      // ---- length boundary ----
      do_reset();
      frame(MAX_LEN, 8'h03, 8'h0A, 8'h11, -1, 1'b0, -1);
      check("t6_len_max", 32'(bus.frameLen), 4096);
      check("t6_lenErr_clear", 32'(bus.lenErr), 0);
      frame(MAX_LEN + 1, 8'h04, 8'h0A, 8'h11, -1, 1'b0, -1);
      check("t6_len_sat", 32'(bus.frameLen), 4096);
      check("t6_lenErr_set", 32'(bus.lenErr), 1);
      check("t6_frameCmd", 32'(bus.frameCmd), 32'h04);

      // ---- reset in the middle of a frame ----
      d0 = done_cnt;
      bus.SPI_SS = 1'b0;
      tick(); tick();
      ev_start = 1'b1; tick(); ev_start = 1'b0;
      bus.rcMemWE = 1'b1; bus.rcMemData = 8'h77; tick(); bus.rcMemWE = 1'b0;
      Reset = 1'b0; tick(); tick(); Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.rcMemWE = 1'b1; bus.rcMemData = 8'(8'h78 + i); tick();
      end
      bus.rcMemWE = 1'b0;
      bus.SPI_SS  = 1'b1;
      tick(); tick();
      ev_end = 1'b1; tick(); ev_end = 1'b0;
      ev_close = 1'b1; tick(); ev_close = 1'b0;
      repeat (5) tick();
      check("t7_no_done", done_cnt - d0, 0);
      frame(1, 8'h3C, 8'h00, 8'h00, -1, 1'b0, -1);
      check("t7_done", done_cnt - d0, 1);
      check("t7_frameLen", 32'(bus.frameLen), 1);
      check("t7_frameCmd", 32'(bus.frameCmd), 32'h3C);

`ifdef SPI_FRAME_CTRL_TIMEOUT_EN
      // ---- watchdog abort ----
      begin
         int to_seen, dn;
         check_en = 1'b0;
         do_reset();
         d0 = done_cnt;
         to_seen = 0;
         bus.SPI_SS = 1'b0;
         repeat (3) tick();
         bus.rcMemWE = 1'b1; bus.rcMemData = 8'h55; tick(); bus.rcMemWE = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge SysClk);
            if (bus.timeout === 1'b1) to_seen++;
         end
         bus.SPI_SS = 1'b1;
         repeat (10) @(negedge SysClk);
         dn = done_cnt - d0;
         check("t8_timeout_pulse", to_seen, 1);
         check("t8_no_done", dn, 0);
         check("t8_busy", 32'(bus.busy), 0);
         do_reset();
         check_en = 1'b1;
      end
`endif

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
